// File: rtl/fifo_pkg.sv
// Shared constants and types for the synchronous FIFO.
// Optional occupancy port is enabled by defining FIFO_COUNT_EN.
package fifo_pkg;

    localparam int DATA_SIZE_DEF  = 8;
    localparam int ADDR_WIDTH_DEF = 4;

    typedef logic [ADDR_WIDTH_DEF-1:0] ptr_t;
    typedef logic [ADDR_WIDTH_DEF:0]   occ_t;

endpackage

// File: rtl/fifo_mem_array.sv
// Simple dual-port register array: synchronous write,
// registered read with read-enable (read register resets to 0).
module fifo_mem_array
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE  = DATA_SIZE_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_SIZE-1:0]  wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_SIZE-1:0]  rdata_o
);

    logic [DATA_SIZE-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_SIZE-1:0] rdata_q;

    // Storage is intentionally left unreset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO: pointers, occupancy and error flag.
// Define FIFO_COUNT_EN to expose the occupancy on port count.
module sync_fifo_core
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE  = DATA_SIZE_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] wdata,
    output logic [DATA_SIZE-1:0] rdata,
    input  logic                 rd_en,
    input  logic                 wr_en,
    output logic                 full,
    output logic                 empty,
    output logic                 error
`ifdef FIFO_COUNT_EN
    ,
    output logic [ADDR_WIDTH:0]  count
`endif
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   occ_q, occ_d;
    logic                  err_q, err_d;
    logic                  wr_acc, rd_acc;

    // Status comes from registered occupancy only.
    assign full  = (occ_q == DEPTH_C);
    assign empty = (occ_q == '0);
    assign error = err_q;

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({wr_acc, rd_acc})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
        err_d = (wr_en && full) || (rd_en && empty);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            err_q    <= err_d;
        end
    end

    fifo_mem_array #(
        .DATA_SIZE  (DATA_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk_i   (clk),
        .rst_ni  (rst),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .re_i    (rd_acc),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

`ifdef FIFO_COUNT_EN
    assign count = occ_q;
`endif

endmodule

// File: tb/tb_sync_fifo_core.sv
// Scoreboard bench for sync_fifo_core with a queue-based reference model.
module tb_sync_fifo_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       rd_en = 1'b0;
    logic       wr_en = 1'b0;
    logic       full, empty, error;
`ifdef FIFO_COUNT_EN
    logic [4:0] count;
`endif

    sync_fifo_core #(.DATA_SIZE(8), .ADDR_WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .wdata (wdata),
        .rdata (rdata),
        .rd_en (rd_en),
        .wr_en (wr_en),
        .full  (full),
        .empty (empty),
        .error (error)
`ifdef FIFO_COUNT_EN
        ,
        .count (count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int    rd;
        int    err;
        int    full;
        int    empty;
        int    cnt;
        string tag;
    } exp_t;

    exp_t  sbq[$];
    int    mq[$];
    int    last_rd = 0;
    int    n_chk = 0;
    int    n_pass = 0;
    string phase = "reset";

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One clock of stimulus; the model works on the pre-edge contents.
    task automatic cycle(bit w, bit r, logic [7:0] d);
        exp_t e;
        bit   f;
        bit   em;
        f  = (mq.size() == 16);
        em = (mq.size() == 0);
        wr_en = w;
        rd_en = r;
        wdata = d;
        e.err = ((w && f) || (r && em)) ? 1 : 0;
        if (r && !em) last_rd = mq.pop_front();
        if (w && !f) mq.push_back(int'(d));
        e.rd    = last_rd;
        e.full  = (mq.size() == 16) ? 1 : 0;
        e.empty = (mq.size() == 0) ? 1 : 0;
        e.cnt   = mq.size();
        e.tag   = phase;
        sbq.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                exp_t e;
                e = sbq.pop_front();
                chk({e.tag, ".rdata"}, int'(rdata), e.rd);
                chk({e.tag, ".error"}, int'(error), e.err);
                chk({e.tag, ".full"}, int'(full), e.full);
                chk({e.tag, ".empty"}, int'(empty), e.empty);
`ifdef FIFO_COUNT_EN
                chk({e.tag, ".count"}, int'(count), e.cnt);
`endif
            end
        end
    end

    task automatic drain();
        int k;
        wr_en = 1'b0;
        rd_en = 1'b0;
        k = 0;
        while (sbq.size() > 0 && k < 5) begin
            @(negedge clk);
            k++;
        end
        chk("drain.pending", sbq.size(), 0);
    endtask

    task automatic reset_checks(string tag);
        chk({tag, ".empty"}, int'(empty), 1);
        chk({tag, ".full"}, int'(full), 0);
        chk({tag, ".error"}, int'(error), 0);
        chk({tag, ".rdata"}, int'(rdata), 0);
`ifdef FIFO_COUNT_EN
        chk({tag, ".count"}, int'(count), 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int wp;
        int rp;
        #12;
        reset_checks("reset");
        @(negedge clk);
        rst = 1'b1;

        phase = "basic";
        cycle(1, 0, 8'h24);
        cycle(1, 0, 8'h81);
        cycle(1, 0, 8'h09);
        cycle(1, 0, 8'h63);
        repeat (3) cycle(0, 1, 8'h00);
        cycle(0, 0, 8'h00);
        cycle(0, 1, 8'h00);

        phase = "overflow";
        for (int i = 0; i < 16; i++) cycle(1, 0, 8'(i));
        cycle(1, 0, 8'hAA);
        cycle(0, 0, 8'h00);
        for (int i = 0; i < 16; i++) cycle(0, 1, 8'h00);

        phase = "underflow";
        cycle(0, 1, 8'h00);
        cycle(0, 0, 8'h00);
        cycle(0, 1, 8'h00);
        cycle(1, 0, 8'h77);
        cycle(0, 1, 8'h00);

        phase = "wrap";
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 10; i++) cycle(1, 0, 8'(8'h30 + k * 10 + i));
            for (int i = 0; i < 10; i++) cycle(0, 1, 8'h00);
        end

        phase = "simul";
        for (int i = 0; i < 5; i++) cycle(1, 0, 8'(8'hC0 + i));
        for (int i = 0; i < 8; i++) cycle(1, 1, 8'(8'hD0 + i));
        for (int i = 0; i < 5; i++) cycle(0, 1, 8'h00);
        cycle(1, 1, 8'h5A);
        cycle(0, 0, 8'h00);
        cycle(0, 1, 8'h00);

        phase = "random";
        for (int p = 0; p < 4; p++) begin
            wp = (p == 0) ? 75 : (p == 1) ? 25 : (p == 2) ? 50 : 90;
            rp = (p == 0) ? 25 : (p == 1) ? 75 : (p == 2) ? 50 : 90;
            for (int i = 0; i < 300; i++) begin
                cycle($urandom_range(99) < wp, $urandom_range(99) < rp,
                      8'($urandom));
            end
        end

        phase = "midreset";
        for (int i = 0; i < 6; i++) cycle(1, 0, 8'(8'hE0 + i));
        cycle(0, 1, 8'h00);
        cycle(1, 1, 8'h00);
        drain();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        reset_checks("midreset");
        mq.delete();
        last_rd = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        phase = "postreset";
        cycle(0, 1, 8'h00);
        cycle(1, 0, 8'h3C);
        cycle(0, 1, 8'h00);

        drain();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sync_fifo_core.md
Name: sync_fifo_core

Overview:
Single-clock synchronous FIFO buffer of 2**ADDR_WIDTH entries of DATA_SIZE bits. It is used between a producer and a consumer in the same clock domain.
- Interface: write-enable / read-enable, with full/empty status.
- Error strobe: pulses when a request is rejected (overflow or underflow attempt).
- Read data: registered.

Parameters:
- DATA_SIZE, 8, width of each data word in bits.
- ADDR_WIDTH, 4, pointer width; DEPTH = 2**ADDR_WIDTH entries, so 16 by default.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset. Asserting rst low clears state immediately; release is synchronous to clk.
- wdata  input  DATA_SIZE  write data, sampled when wr_en=1 at the clk rising edge.
- rdata  output  DATA_SIZE  registered read data.
- rd_en  input  1  read request.
- wr_en  input  1  write request.
- full  output  1  high when DEPTH entries are stored.
- empty  output  1  high when 0 entries are stored.
- error  output  1  one-cycle flag for a rejected request.

Behaviour:
- Reset (rst=0), asynchronous:
  - wr_ptr=0, rd_ptr=0, occupancy=0.
  - empty=1, full=0, error=0, rdata=0.
  - Memory array contents are not reset.
- Internal state:
  - wr_ptr and rd_ptr are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
  - occupancy is ADDR_WIDTH+1 bits, range 0..DEPTH.
- Status outputs:
  - full = (occupancy==DEPTH); empty = (occupancy==0).
  - Both are decoded from registered state only, with no combinational path from wr_en or rd_en.
- Acceptance is evaluated on the pre-edge state:
  - A write is accepted iff wr_en && !full.
  - A read is accepted iff rd_en && !empty.
- Accepted write: mem[wr_ptr] <= wdata; wr_ptr increments.
- Accepted read:
  - rdata <= mem[rd_ptr]; rd_ptr increments.
  - Data is visible on rdata one cycle after the edge that sampled rd_en (latency 1).
  - rdata holds its last value when no read is accepted.
- Simultaneous read and write, both accepted: occupancy is unchanged and both pointers advance.
- Write while full:
  - The write is rejected and memory is not modified.
  - If rd_en is also high, the read is still accepted.
- Read while empty:
  - The read is rejected and rdata holds.
  - If wr_en is also high, the write is still accepted.
- error:
  - Registered; set to 1 for exactly the cycle after any rejected request (overflow or underflow).
  - Otherwise 0. It is not sticky.
- Ordering: strict first-in first-out, including across pointer wrap-around.
- Reset mid-operation: all flags and pointers return to their reset values immediately; in-flight requests are discarded.

Optional Feature:
- Macro FIFO_COUNT_EN.
- When defined: an extra output port `count` [ADDR_WIDTH:0] is present, equal to the registered occupancy (0..DEPTH). It resets to 0 and updates on the same edge as full/empty.
- When undefined: the port and any logic dedicated to it are absent. Occupancy tracking for full/empty is still present.

Decomposition:
- Package fifo_pkg:
  - default constants DATA_SIZE_DEF=8 and ADDR_WIDTH_DEF=4;
  - typedef for the pointer (logic [ADDR_WIDTH_DEF-1:0]);
  - typedef for occupancy (logic [ADDR_WIDTH_DEF:0]).
- Sub-module fifo_mem_array:
  - simple dual-port register array, DEPTH x DATA_SIZE;
  - synchronous write port; registered read port with a read-enable.
  - Pointer, occupancy and flag logic stays in sync_fifo_core.

Test Plan:
- Reset: hold rst=0 for 10 ns with clocks running -> empty=1, full=0, error=0, rdata=0; asserting rst low mid-cycle clears the flags without waiting for an edge.
- Basic order: write 0x24, 0x81, 0x09, 0x63, then read 3 -> rdata shows 0x24, 0x81, 0x09 on successive cycles; empty=0 with 1 entry left; error stays 0.
- Full/overflow: write 16 words (0x00..0x0F) -> full=1 after the 16th edge. A 17th write of 0xAA -> error=1 for one cycle. A subsequent 16 reads return 0x00..0x0F (0xAA is never seen).
- Empty/underflow: read from empty -> error=1 for one cycle, rdata holds its previous value, pointers are unchanged.
- Wrap-around: write 10 / read 10 twice, with 20 distinct values -> all 20 values are read back in order and empty=1 at the end.
- Simultaneous: with 5 entries stored, assert wr_en and rd_en for 8 cycles -> full/empty unchanged and the 5 entries remain; with FIFO_COUNT_EN, count=5 throughout. On an empty FIFO with both asserted -> the write is accepted, error=1, and the next cycle empty=0.
